// File: rtl/ro_event_packer_if.sv
// Readout-bus / output-stream bundle for ro_event_packer.
// master: the side driving the gray count and bus lines and consuming words.
// slave : the packer itself.
interface ro_event_packer_if #(
  parameter int N_CH = 8,
  parameter int TS_W = 16
) ();
  logic [N_CH-1:0] gray;
  logic            bus_eve;
  logic            bus_pol;
  logic [TS_W+5:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            overflow;
  logic            gray_err;
  logic [7:0]      drop_cnt;

  modport master (
    output gray, bus_eve, bus_pol, out_ready,
    input  out_data, out_valid, overflow, gray_err, drop_cnt
  );

  modport slave (
    input  gray, bus_eve, bus_pol, out_ready,
    output out_data, out_valid, overflow, gray_err, drop_cnt
  );
endinterface

// File: rtl/ro_event_packer.sv
// ro_event_packer: watches the gray-count slot schedule of the readout
// blocks, samples the shared event bus in each channel slot and packs
// {timestamp, channel, polarity} words into a show-ahead FIFO.
//
// Pipeline (edges counted from the edge that first sees a new gray value):
//   edge 1: gray registered, gray ^ previous gray registered as diff
//   edge 2: diff decoded, bus_eve/bus_pol and ts sampled into a candidate
//   edge 3: candidate written into the FIFO (out_valid visible afterwards)
module ro_event_packer #(
  parameter int N_CH     = 8,
  parameter int TS_W     = 16,
  parameter int DEPTH    = 16,
  parameter int EMIT_ALL = 0
) (
  input  logic             clk_master,
  input  logic             rst,
  ro_event_packer_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int DW   = TS_W + 6;
  localparam int CH_W = 5;

  localparam logic [N_CH-1:0] DIFF_ONE = N_CH'(1);
  localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);
  localparam logic [AW:0]     PTR_ONE  = (AW + 1)'(1);

  // ---------------------------------------------------------------------
  // Stage 1: gray history and registered bit-change vector
  // ---------------------------------------------------------------------
  logic [N_CH-1:0] gray_dly_q;   // previous gray sample
  logic [N_CH-1:0] diff_q;       // bits that changed on the last edge
  logic            diff_vld_q;   // diff_q compares two real samples
  logic            prime_q;      // gray_dly_q holds a real sample

  // Register gray and compare it against the previous sample; the very first
  // compare after reset is against the reset value and is marked invalid.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      gray_dly_q <= '0;
      diff_q     <= '0;
      diff_vld_q <= 1'b0;
      prime_q    <= 1'b0;
    end else begin
      gray_dly_q <= bus.gray;
      diff_q     <= bus.gray ^ gray_dly_q;
      diff_vld_q <= prime_q;
      prime_q    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Slot decode
  // ---------------------------------------------------------------------
  logic            diff_any;
  logic            diff_multi;
  logic            slot_onehot;
  logic [CH_W-1:0] slot_ch;

  // x & (x-1) clears the lowest set bit: non-zero means two or more bits.
  assign diff_any    = |diff_q;
  assign diff_multi  = |(diff_q & (diff_q - DIFF_ONE));
  assign slot_onehot = diff_any && !diff_multi;

  // Onehot-to-index encoder: index bit gi is the OR of all diff bits whose
  // position has bit gi set. Only meaningful when slot_onehot is true.
  genvar gi, gk;
  generate
    for (gi = 0; gi < CH_W; gi++) begin : g_ch_bit
      logic [N_CH-1:0] sel;
      for (gk = 0; gk < N_CH; gk++) begin : g_sel
        assign sel[gk] = (((gk >> gi) % 2) == 1);
      end
      assign slot_ch[gi] = |(diff_q & sel);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_ONE;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: bus sampling and candidate word
  // ---------------------------------------------------------------------
  logic          cand_vld_q;
  logic [DW-1:0] cand_word_q;
  logic          gray_err_q;

  // Sample the bus in the decoded slot; flag multi-bit gray jumps (sticky).
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      cand_vld_q  <= 1'b0;
      cand_word_q <= '0;
      gray_err_q  <= 1'b0;
    end else begin
      cand_vld_q  <= diff_vld_q && slot_onehot && ((EMIT_ALL != 0) || bus.bus_eve);
      cand_word_q <= {ts_q, slot_ch, bus.bus_pol};
      if (diff_vld_q && diff_multi) begin
        gray_err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: FIFO
  // ---------------------------------------------------------------------
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          overflow_q;
  logic [7:0]    drop_cnt_q;

  logic fifo_empty;
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = !fifo_empty && bus.out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO
  // is still accepted when the consumer is taking the head word.
  assign do_push    = cand_vld_q && (!fifo_full || do_pop);
  assign do_drop    = cand_vld_q && fifo_full && !do_pop;

  // Storage array; no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk_master) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cand_word_q;
    end
  end

  // Pointer bookkeeping plus sticky overflow and saturating drop counter.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (do_drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  // Show-ahead head word; forced to zero while empty so stale RAM contents
  // never appear on the output (e.g. right after reset).
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.overflow  = overflow_q;
  assign bus.gray_err  = gray_err_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
